// File: rtl/conv_pkg.sv
// Shared types and width helper for the linear convolution engine.
// Optional feature macro: CONV_SAT_EN (saturating result narrowing).
package conv_pkg;

    // Controller states: operand capture, per-output accumulation,
    // result hand-off, completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } conv_state_t;

    // Accumulator width able to hold a full N-term sum of W x W signed
    // products without overflow.
    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/linear_conv_engine_if.sv
// Request/result bundle of the linear convolution engine.
// The engine side uses the slave modport, the requester the master modport.
interface linear_conv_engine_if #(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int OUT_W = 2 * W + $clog2(N)
);
    logic                          start;
    logic [N*W-1:0]                x_in;
    logic [N*W-1:0]                h_in;
    logic                          busy;
    logic signed [OUT_W-1:0]       y_data;
    logic [$clog2(2*N-1)-1:0]      y_idx;
    logic                          y_valid;
    logic                          y_ready;
    logic                          done;

    modport slave (
        input  start, x_in, h_in, y_ready,
        output busy, y_data, y_idx, y_valid, done
    );

    modport master (
        output start, x_in, h_in, y_ready,
        input  busy, y_data, y_idx, y_valid, done
    );
endinterface

// File: rtl/conv_mac.sv
// Signed multiply-accumulate datapath: one product per enabled cycle,
// synchronous clear has priority over accumulation.
module conv_mac #(
    parameter int W     = 8,
    parameter int ACC_W = 19
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_reg;

    assign prod     = a * b;
    assign prod_ext = {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
    assign acc      = acc_reg;

    // Accumulator register: clear on a new output index, add when enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end

endmodule

// File: rtl/linear_conv_engine.sv
// Full linear convolution y = x * h of two N-sample signed sequences.
// Each output y[k] is built by a serial MAC over the valid overlap range,
// then offered on a valid/ready port. Optional macro CONV_SAT_EN selects
// saturating instead of wrapping narrowing when OUT_W is below the
// accumulator width.
module linear_conv_engine
    import conv_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 8,
    parameter int OUT_W = 2 * W + $clog2(N)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    linear_conv_engine_if.slave   bus
);

    localparam int ACC_W = acc_width(N, W);
    localparam int K_W   = $clog2(2 * N - 1);
    localparam int I_W   = $clog2(N);
    localparam logic [K_W-1:0] K_LAST = K_W'(2 * N - 2);
    localparam logic [K_W-1:0] N_M1   = K_W'(N - 1);

    conv_state_t       state_reg, state_next;
    logic [K_W-1:0]    k_reg, k_next;
    logic [K_W-1:0]    i_reg, i_next;
    logic              load_ops;
    logic              acc_clr;
    logic              acc_en;

    logic signed [W-1:0]     x_samp [N];
    logic signed [W-1:0]     h_samp [N];
    logic signed [W-1:0]     x_reg  [N];
    logic signed [W-1:0]     h_reg  [N];
    logic signed [W-1:0]     mac_a;
    logic signed [W-1:0]     mac_b;
    logic signed [ACC_W-1:0] acc;
    logic signed [OUT_W-1:0] y_red;
    logic [K_W-1:0]          i_hi;
    logic [I_W-1:0]          x_idx;
    logic [I_W-1:0]          h_idx;
    logic [K_W-1:0]          h_off;
    logic                    y_valid_int;

    // First product index of output k: the overlap starts once k >= N.
    function automatic logic [K_W-1:0] lo_of(input logic [K_W-1:0] k);
        return (k > N_M1) ? (k - N_M1) : '0;
    endfunction

    // Last product index of output k: capped at the end of x.
    function automatic logic [K_W-1:0] hi_of(input logic [K_W-1:0] k);
        return (k > N_M1) ? N_M1 : k;
    endfunction

    // Unpack the flat operand buses and hold captured samples per element.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ops
            assign x_samp[gi] = bus.x_in[gi*W +: W];
            assign h_samp[gi] = bus.h_in[gi*W +: W];

            // Capture operand pair gi when a request is accepted.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    x_reg[gi] <= '0;
                    h_reg[gi] <= '0;
                end else if (load_ops) begin
                    x_reg[gi] <= x_samp[gi];
                    h_reg[gi] <= h_samp[gi];
                end
            end
        end
    endgenerate

    // Product selection: x[i] * h[k-i]; both indices stay within 0..N-1.
    assign i_hi  = hi_of(k_reg);
    assign h_off = k_reg - i_reg;
    assign x_idx = i_reg[I_W-1:0];
    assign h_idx = h_off[I_W-1:0];
    assign mac_a = x_reg[x_idx];
    assign mac_b = h_reg[h_idx];

    conv_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (acc_clr),
        .en      (acc_en),
        .a       (mac_a),
        .b       (mac_b),
        .acc     (acc)
    );

    // Controller and index registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            i_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            i_reg     <= i_next;
        end
    end

    // Next-state, index stepping and datapath controls.
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        i_next     = i_reg;
        load_ops   = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    load_ops   = 1'b1;
                    acc_clr    = 1'b1;
                    k_next     = '0;
                    i_next     = '0;
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_en = 1'b1;
                if (i_reg == i_hi) begin
                    state_next = ST_EMIT;
                end else begin
                    i_next = i_reg + 1'b1;
                end
            end
            ST_EMIT: begin
                if (bus.y_ready) begin
                    if (k_reg == K_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        k_next     = k_reg + 1'b1;
                        i_next     = lo_of(k_reg + 1'b1);
                        acc_clr    = 1'b1;
                        state_next = ST_MAC;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Narrow the accumulator to the output width.
    generate
        if (OUT_W >= ACC_W) begin : g_extend
            assign y_red = OUT_W'(acc);
        end else begin : g_narrow
`ifdef CONV_SAT_EN
            localparam logic signed [ACC_W-1:0] SAT_MAX =
                {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
            localparam logic signed [ACC_W-1:0] SAT_MIN =
                {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

            // Clamp out-of-range sums to the nearest representable value.
            always_comb begin
                y_red = acc[OUT_W-1:0];
                if (acc > SAT_MAX) begin
                    y_red = {1'b0, {(OUT_W - 1){1'b1}}};
                end else if (acc < SAT_MIN) begin
                    y_red = {1'b1, {(OUT_W - 1){1'b0}}};
                end
            end
`else
            assign y_red = acc[OUT_W-1:0];
`endif
        end
    endgenerate

    // Result port is zero outside EMIT so idle outputs read as 0.
    assign y_valid_int = (state_reg == ST_EMIT);
    assign bus.y_valid = y_valid_int;
    assign bus.y_data  = y_valid_int ? y_red : '0;
    assign bus.y_idx   = y_valid_int ? k_reg : '0;
    assign bus.busy    = (state_reg == ST_MAC) || (state_reg == ST_EMIT);
    assign bus.done    = (state_reg == ST_DONE);

endmodule

// File: doc/linear_conv_engine.md
LINEAR_CONV_ENGINE -- requirements
Module: linear_conv_engine

Interface
REQ-001 SHALL have parameter N, default 8, sequence length per operand (2..16).
REQ-002 SHALL have parameter W, default 8, signed sample width.
REQ-003 SHALL have parameter OUT_W, default 2*W+$clog2(N) (19), signed result width.
REQ-004 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  single-cycle request to latch operands and begin.
REQ-007 SHALL have port x_in  in  N*W  sample x[i] at bits [i*W +: W].
REQ-008 SHALL have port h_in  in  N*W  sample h[i] at bits [i*W +: W].
REQ-009 SHALL have port busy  out  1  high from the cycle after start acceptance until done.
REQ-010 SHALL have port y_data  out  OUT_W  result y[k].
REQ-011 SHALL have port y_idx  out  $clog2(2N-1)  index k of y_data.
REQ-012 SHALL have port y_valid  out  1  y_data/y_idx valid.
REQ-013 SHALL have port y_ready  in  1  consumer accepts when y_valid && y_ready.
REQ-014 SHALL have port done  out  1  one-cycle pulse after last result accepted.

Function
REQ-015 SHALL compute y[k] = sum over i of x[i]*h[k-i], k = 0..2N-2, i in [max(0,k-N+1), min(k,N-1)], signed.
REQ-016 SHALL use FSM IDLE -> MAC -> EMIT -> (MAC | DONE) -> IDLE.
REQ-017 IDLE: start=1 latches x_in/h_in, sets k=0, clears accumulator, enters MAC; later changes on x_in/h_in SHALL have no effect.
REQ-018 MAC: one product per cycle, i ascending from i_lo to i_hi; after the i_hi product, enter EMIT.
REQ-019 EMIT: y_valid=1, y_data=acc (width-reduced per REQ-028), y_idx=k; y_data/y_idx SHALL stay stable while y_valid && !y_ready.
REQ-020 On EMIT handshake: k<2N-2 -> k+1, clear acc, MAC; k=2N-2 -> DONE.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-022 start while not IDLE SHALL be ignored.
REQ-023 Accumulator SHALL be 2*W+$clog2(N) bits signed; no internal overflow possible.
REQ-024 With y_ready held 1, done SHALL assert N*N+2N cycles after the start-sampling edge (80 for N=8).

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE; busy, y_valid, done, y_data, y_idx, k, acc all 0.
REQ-026 Reset mid-operation SHALL abandon the computation; no partial result or done emitted.
REQ-027 First start after reset release SHALL behave identically to power-up.

Configuration
REQ-028 Macro CONV_SAT_EN: defined -> y_data saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when acc exceeds OUT_W; undefined -> y_data = low OUT_W bits of acc (two's-complement wrap). No effect when OUT_W >= accumulator width.

Structure
REQ-029 Package conv_pkg SHALL hold the FSM state enum and the width function acc_width(N,W).
REQ-030 Sub-module conv_mac SHALL hold the signed multiplier and accumulator (clear, enable inputs); FSM and index counters in linear_conv_engine.

Verification (N=8, W=8)
REQ-031 x all 1, h all 1, y_ready=1 -> y = 1,2,..,8,7,..,1 at y_idx 0..14; done at cycle 80.
REQ-032 x[0]=1 rest 0, h=1..8 -> y[0..7]=1..8, y[8..14]=0.
REQ-033 x,h all -128, OUT_W=16: y[7] acc=131072 -> 0 without CONV_SAT_EN, 32767 with it; default OUT_W gives 131072.
REQ-034 y_ready=0 for 5 cycles at k=3 -> y_valid held, y_data=4 (all-ones case) stable, no index skipped; start pulsed while busy ignored.
REQ-035 reset_n low at k=5 in MAC -> all outputs 0 immediately, no done; new start then yields REQ-031 results exactly.
